// File: rtl/ysyx_25070198_sram.sv
// Memory-side SimpleBus responder: one request at a time, fixed access latency,
// word reads and byte-masked word writes on local storage, held response.
module ysyx_25070198_sram #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int unsigned LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int unsigned WORDS     = 1 << DEPTH_LOG2;
  localparam logic [32:0] WIN_BYTES = 33'd4 << DEPTH_LOG2;
  localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        wen_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wmask_q;

  logic [31:0] mem [WORDS];

  logic                  accept, access, mem_we, in_range;
  logic                  acc_wen;
  logic [31:0]           acc_addr, acc_wdata, offset;
  logic [3:0]            acc_wmask;
  logic [DEPTH_LOG2-1:0] idx;

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign accept     = req_valid && req_ready;

  // With LATENCY==1 the access happens on the accept edge, so the live
  // request fields are used instead of the not-yet-loaded capture registers.
  always_comb begin
    acc_wen   = wen_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_wmask = wmask_q;
    if (state_q == IDLE) begin
      acc_wen   = req_wen;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wmask = req_wmask;
    end
    offset   = acc_addr - BASE;
    in_range = {1'b0, offset} < WIN_BYTES;
    idx      = offset[DEPTH_LOG2+1:2];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY > 1) begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end else begin
            access  = 1'b1;
            state_d = RESP;
          end
        end
      end
      BUSY: begin
        if (cnt_q <= 4'd1) begin
          access  = 1'b1;
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (access) begin
      err_d   = !in_range;
      rdata_d = (in_range && !acc_wen) ? mem[idx] : '0;
    end
    mem_we = access && in_range && acc_wen && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wen_q   <= req_wen;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wmask_q <= req_wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (acc_wmask[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end
endmodule
